// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int ADDR_W_DEFAULT = 18;
  localparam int DATA_W_DEFAULT = 16;

  localparam int PORT_LOADER = 0;
  localparam int PORT_CPU    = 1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two request ports plus shared status.
interface sram_arbiter_if #(
  parameter int ADDR_W = sram_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = sram_pkg::DATA_W_DEFAULT
);
  logic [1:0]          rq_req;
  logic [1:0]          rq_we;
  logic [3:0]          rq_be;
  logic [2*ADDR_W-1:0] rq_addr;
  logic [2*DATA_W-1:0] rq_wdata;
  logic [1:0]          rq_ack;
  logic [DATA_W-1:0]   rq_rdata;
  logic                grant_id;
  logic                busy;

  modport master (
    output rq_req, rq_we, rq_be, rq_addr, rq_wdata,
    input  rq_ack, rq_rdata, grant_id, busy
  );

  modport slave (
    input  rq_req, rq_we, rq_be, rq_addr, rq_wdata,
    output rq_ack, rq_rdata, grant_id, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the caller owns and updates 'last'.
module rr_arb2
  import sram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'(PORT_LOADER);
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[PORT_CPU]) begin
      grant = 1'(PORT_CPU);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the loader and CPU ports with a
// fixed setup / strobe / recover access sequence.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  sram_arbiter_if.slave     rq,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              wre,
  output logic              oute,
  output logic              hb_mask,
  output logic              lb_mask,
  output logic              chip_en
);

  state_t state, state_next;

  logic              last;
  logic              grant_q;
  logic              win;
  logic              lat_we;
  logic [1:0]        lat_be;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        cnt;
  logic              data_oe;

  logic              sel_we;
  logic [1:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req   (rq.rq_req),
    .last  (last),
    .grant (win)
  );

  always_comb begin
    sel_we    = rq.rq_we[win];
    sel_be    = win ? rq.rq_be[3:2] : rq.rq_be[1:0];
    sel_addr  = win ? rq.rq_addr[2*ADDR_W-1:ADDR_W] : rq.rq_addr[ADDR_W-1:0];
    sel_wdata = win ? rq.rq_wdata[2*DATA_W-1:DATA_W] : rq.rq_wdata[DATA_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      grant_q   <= 1'b0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
      data_oe   <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (|rq.rq_req) begin
            grant_q   <= win;
            last      <= win;
            lat_we    <= sel_we;
            lat_be    <= sel_be;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            data_oe   <= sel_we;
          end
        end
        SETUP:   cnt <= 4'(WAIT_STATES);
        STROBE: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (!lat_we) begin
            rdata_q <= data;
          end
        end
        RECOVER: data_oe <= 1'b0;
        default: ;
      endcase
    end
  end

  // Every SRAM pin and the ack are decoded from the state register and the
  // latched request, so no requester input reaches them combinationally.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|rq.rq_req) state_next = SETUP;
      SETUP:   state_next = STROBE;
      STROBE:  if (cnt == '0) state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    chip_en            = (state == SETUP) || (state == STROBE);
    wre                = (state == STROBE) && lat_we;
    oute               = ((state == SETUP) || (state == STROBE)) && !lat_we;
    {hb_mask, lb_mask} = (state == IDLE) ? 2'b00 : lat_be;
    addr               = lat_addr;

    rq.rq_ack = '0;
    if (state == RECOVER) rq.rq_ack[grant_q] = 1'b1;
  end

  assign rq.rq_rdata = rdata_q;
  assign rq.grant_id = grant_q;
  assign rq.busy     = (state != IDLE);

  assign data = data_oe ? lat_wdata : 'z;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter against a cycle-table and memory model.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;

  typedef struct packed {
    logic          ce, wre, oe, hb, lb, busy;
    logic [1:0]    ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } pins_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  logic          sel = 1'b0;
  logic [1:0]    req = '0, we = '0;
  logic [3:0]    be = '0;
  logic [2*AW-1:0] raddr = '0;
  logic [2*DW-1:0] wdata = '0;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  assign bus0.rq_req = sel ? 2'b00 : req;
  assign bus3.rq_req = sel ? req : 2'b00;
  assign bus0.rq_we = we;       assign bus3.rq_we = we;
  assign bus0.rq_be = be;       assign bus3.rq_be = be;
  assign bus0.rq_addr = raddr;  assign bus3.rq_addr = raddr;
  assign bus0.rq_wdata = wdata; assign bus3.rq_wdata = wdata;

  logic [AW-1:0] a0, a3;
  wire  [DW-1:0] d0, d3;
  logic wre0, oe0, hb0, lb0, ce0, wre3, oe3, hb3, lb3, ce3;

  sram_arbiter #(.WAIT_STATES(0), .ADDR_W(AW), .DATA_W(DW)) dut0 (
    .clock(clock), .reset(reset), .rq(bus0.slave), .addr(a0), .data(d0),
    .wre(wre0), .oute(oe0), .hb_mask(hb0), .lb_mask(lb0), .chip_en(ce0)
  );

  sram_arbiter #(.WAIT_STATES(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
    .clock(clock), .reset(reset), .rq(bus3.slave), .addr(a3), .data(d3),
    .wre(wre3), .oute(oe3), .hb_mask(hb3), .lb_mask(lb3), .chip_en(ce3)
  );

  // Released bus reads as all ones; write data never uses that value.
  pullup pu0 [DW-1:0] (d0);
  pullup pu3 [DW-1:0] (d3);

  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  assign d0 = (ce0 && oe0 && !wre0) ? mem0[a0] : 'z;
  assign d3 = (ce3 && oe3 && !wre3) ? mem3[a3] : 'z;
  always @(posedge clock) begin
    if (ce0 && wre0) begin
      if (hb0) mem0[a0][15:8] <= d0[15:8];
      if (lb0) mem0[a0][7:0]  <= d0[7:0];
    end
    if (ce3 && wre3) begin
      if (hb3) mem3[a3][15:8] <= d3[15:8];
      if (lb3) mem3[a3][7:0]  <= d3[7:0];
    end
  end

  logic [1:0]    s_ack;
  logic [DW-1:0] s_rdata, s_data;
  logic [AW-1:0] s_addr;
  logic          s_gid, s_busy, s_ce, s_wre, s_oe, s_hb, s_lb;
  assign s_ack   = sel ? bus3.rq_ack   : bus0.rq_ack;
  assign s_rdata = sel ? bus3.rq_rdata : bus0.rq_rdata;
  assign s_gid   = sel ? bus3.grant_id : bus0.grant_id;
  assign s_busy  = sel ? bus3.busy     : bus0.busy;
  assign s_addr  = sel ? a3 : a0;
  assign s_data  = sel ? d3 : d0;
  assign s_ce    = sel ? ce3 : ce0;
  assign s_wre   = sel ? wre3 : wre0;
  assign s_oe    = sel ? oe3 : oe0;
  assign s_hb    = sel ? hb3 : hb0;
  assign s_lb    = sel ? lb3 : lb0;

  logic [DW-1:0] ref0 [int];
  logic [DW-1:0] ref3 [int];
  logic [DW-1:0] exp_rd [2];
  pins_t         snap [0:23];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (sel) return ref3.exists(int'(a)) ? ref3[int'(a)] : '0;
    return ref0.exists(int'(a)) ? ref0[int'(a)] : '0;
  endfunction

  task automatic ref_wr(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [1:0] b);
    logic [DW-1:0] v;
    v = ref_rd(a);
    if (b[1]) v[15:8] = wd[15:8];
    if (b[0]) v[7:0]  = wd[7:0];
    if (sel) ref3[int'(a)] = v;
    else     ref0[int'(a)] = v;
  endtask

  // Expected pins in cycle i of an access seen in IDLE at cycle 0.
  function automatic void tl_expect(input int i, input int ws, input int p, input logic wr,
                                    input logic [1:0] b, input logic [AW-1:0] a,
                                    input logic [DW-1:0] wd, input logic [DW-1:0] mv,
                                    output pins_t e, output pins_t m);
    logic setup, strobe, recover;
    setup   = (i == 1);
    strobe  = (i >= 2) && (i <= 2 + ws);
    recover = (i == 3 + ws);
    e = '0;
    m = '1;
    e.ce   = setup || strobe;
    e.wre  = strobe && wr;
    e.oe   = (setup || strobe) && !wr;
    e.busy = (i >= 1) && (i <= 3 + ws);
    e.ack  = recover ? ((p == 1) ? 2'b10 : 2'b01) : 2'b00;
    if (setup || strobe) begin
      {e.hb, e.lb} = b;
      e.addr = a;
    end else begin
      m.hb = 1'b0;
      m.lb = 1'b0;
      m.addr = '0;
    end
    if (wr && i >= 1 && i <= 3 + ws) e.data = wd;
    else if (!wr && (setup || strobe)) e.data = mv;
    else e.data = '1;
  endfunction

  // Call at #1 after a rising edge with the selected DUT idle.
  task automatic access(input int p, input logic wr, input logic [1:0] b,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd, output int lat);
    lat = -1;
    req = '0;
    we[p] = wr;
    be[2*p +: 2] = b;
    raddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = wd;
    req[p] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      snap[i] = {s_ce, s_wre, s_oe, s_hb, s_lb, s_busy, s_ack, s_addr, s_data};
      if (s_wre && (s_oe || !s_ce)) viol++;
      if (s_ack[p] && lat < 0) lat = i;
      @(posedge clock);
      #1;
      if (lat >= 0) break;
      we[p] = 1'($urandom);
      be[2*p +: 2] = 2'($urandom);
      raddr[p*AW +: AW] = AW'($urandom);
      wdata[p*DW +: DW] = DW'($urandom);
    end
    req = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic test_reset();
    req = '0;
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      @(negedge clock);
      checks++; if (s_ack !== 2'b00) begin failures++; $display("FAIL reset_ack dut=%0d got=%b want=00", s, s_ack); end
      checks++; if (s_rdata !== '0) begin failures++; $display("FAIL reset_rdata dut=%0d got=%h want=0", s, s_rdata); end
      checks++; if (s_gid !== 1'b0) begin failures++; $display("FAIL reset_grant dut=%0d got=%b want=0", s, s_gid); end
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL reset_busy dut=%0d got=%b want=0", s, s_busy); end
      checks++; if (s_addr !== '0) begin failures++; $display("FAIL reset_addr dut=%0d got=%h want=0", s, s_addr); end
      checks++; if ({s_wre, s_oe, s_hb, s_lb, s_ce} !== 5'b0) begin
        failures++; $display("FAIL reset_pins dut=%0d got=%b want=00000", s, {s_wre, s_oe, s_hb, s_lb, s_ce});
      end
      checks++; if (s_data !== 16'hFFFF) begin failures++; $display("FAIL reset_data_z dut=%0d got=%h want=released(ffff)", s, s_data); end
      @(posedge clock);
      #1;
    end
    sel = 1'b0;
  endtask

  task automatic test_single_write();
    int lat;
    sel = 1'b0;
    access(0, 1'b1, 2'b11, 18'h00010, 16'hBEEF, lat);
    ref_wr(18'h00010, 16'hBEEF, 2'b11);
    checks++; if (lat !== 3) begin failures++; $display("FAIL sw_latency got=%0d want=3", lat); end
    checks++; if ({snap[2].wre, snap[2].ce} !== 2'b11) begin failures++; $display("FAIL sw_strobe_pins got=%b want=11", {snap[2].wre, snap[2].ce}); end
    checks++; if (snap[2].data !== 16'hBEEF) begin failures++; $display("FAIL sw_data got=%h want=beef", snap[2].data); end
    checks++; if (snap[2].addr !== 18'h00010) begin failures++; $display("FAIL sw_addr got=%h want=00010", snap[2].addr); end
    checks++; if (snap[3].ack !== 2'b01) begin failures++; $display("FAIL sw_ack got=%b want=01", snap[3].ack); end
    access(1, 1'b0, 2'b11, 18'h00010, 16'h0000, lat);
    exp_rd[0] = 16'hBEEF;
    checks++; if (s_rdata !== 16'hBEEF) begin failures++; $display("FAIL sw_readback got=%h want=beef", s_rdata); end
  endtask

  task automatic test_byte_lane();
    int lat;
    sel = 1'b0;
    access(1, 1'b1, 2'b01, 18'h00010, 16'h12AB, lat);
    ref_wr(18'h00010, 16'h12AB, 2'b01);
    checks++; if ({snap[2].hb, snap[2].lb} !== 2'b01) begin failures++; $display("FAIL bl_masks got=%b want=01", {snap[2].hb, snap[2].lb}); end
    checks++; if (snap[3].ack !== 2'b10) begin failures++; $display("FAIL bl_ack got=%b want=10", snap[3].ack); end
    checks++; if (s_rdata !== 16'hBEEF) begin failures++; $display("FAIL bl_rdata_held got=%h want=beef", s_rdata); end
    access(0, 1'b0, 2'b11, 18'h00010, 16'h0000, lat);
    exp_rd[0] = 16'hBEAB;
    checks++; if (s_rdata !== 16'hBEAB) begin failures++; $display("FAIL bl_readback got=%h want=beab", s_rdata); end
  endtask

  task automatic test_contention();
    int ackc [2];
    logic gidv [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    int lat;
    sel = 1'b0;
    apply_reset();
    for (int q = 0; q < 2; q++) begin
      ackc[q] = -1;
      gidv[q] = 1'bx;
      ad[q] = AW'($urandom_range(16'h0100, 16'h0FFF)) + AW'(q * 16'h1000);
      wd[q] = DW'($urandom_range(0, 16'hFFFE));
      we[q] = 1'b1;
      be[2*q +: 2] = 2'b11;
      raddr[q*AW +: AW] = ad[q];
      wdata[q*DW +: DW] = wd[q];
    end
    req = 2'b11;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      for (int q = 0; q < 2; q++)
        if (s_ack[q] && ackc[q] < 0) begin ackc[q] = i; gidv[q] = s_gid; end
      @(posedge clock);
      #1;
      for (int q = 0; q < 2; q++) if (ackc[q] >= 0) req[q] = 1'b0;
      if (ackc[0] >= 0 && ackc[1] >= 0) break;
    end
    req = '0;
    @(posedge clock);
    #1;
    checks++; if (ackc[0] !== 3) begin failures++; $display("FAIL ct_ack0_cycle got=%0d want=3", ackc[0]); end
    checks++; if (ackc[1] !== 7) begin failures++; $display("FAIL ct_ack1_cycle got=%0d want=7", ackc[1]); end
    checks++; if ({gidv[0], gidv[1]} !== 2'b01) begin failures++; $display("FAIL ct_grant_order got=%b want=01", {gidv[0], gidv[1]}); end
    for (int q = 0; q < 2; q++) ref_wr(ad[q], wd[q], 2'b11);
    for (int q = 0; q < 2; q++) begin
      access(1 - q, 1'b0, 2'b11, ad[q], 16'h0000, lat);
      exp_rd[0] = ref_rd(ad[q]);
      checks++; if (s_rdata !== exp_rd[0]) begin failures++; $display("FAIL ct_readback%0d got=%h want=%h", q, s_rdata, exp_rd[0]); end
    end
  endtask

  task automatic test_wait_states();
    int lat, bi, oecnt;
    logic anywre;
    logic [AW-1:0] a;
    logic [DW-1:0] mv;
    pins_t e, m, eb;
    sel = 1'b1;
    a = 18'h2A5A5;
    for (int k = 0; k < 2; k++) begin
      mv = ref_rd(a);
      access(k, (k == 0), 2'b11, a, 16'hC0DE, lat);
      checks++; if (lat !== 6) begin failures++; $display("FAIL ws_latency op=%0d got=%0d want=6", k, lat); end
      bi = -1;
      eb = '0;
      for (int i = 0; i <= 6; i++) begin
        tl_expect(i, 3, k, (k == 0), 2'b11, a, 16'hC0DE, mv, e, m);
        if ((((snap[i] ^ e) & m) !== '0) && bi < 0) begin bi = i; eb = e; end
      end
      checks++; if (bi >= 0) begin failures++; $display("FAIL ws_timeline op=%0d cycle=%0d got=%h want=%h", k, bi, snap[bi], eb); end
      if (k == 0) ref_wr(a, 16'hC0DE, 2'b11);
    end
    oecnt = 0;
    anywre = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      if (i >= 2 && snap[i].oe) oecnt++;
      anywre = anywre | snap[i].wre;
    end
    checks++; if (oecnt !== 4) begin failures++; $display("FAIL ws_strobe_oute got=%0d want=4", oecnt); end
    checks++; if (anywre !== 1'b0) begin failures++; $display("FAIL ws_read_wre got=%b want=0", anywre); end
    exp_rd[1] = 16'hC0DE;
    checks++; if (s_rdata !== 16'hC0DE) begin failures++; $display("FAIL ws_rdata got=%h want=c0de", s_rdata); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, acks;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    sel = 1'b0;
    a = 18'h3FFFF;
    v = ref_rd(a);
    we[0] = 1'b1;
    be[1:0] = 2'b11;
    raddr[AW-1:0] = a;
    wdata[DW-1:0] = v;
    req = 2'b01;
    repeat (2) begin @(posedge clock); #1; end
    @(negedge clock);
    checks++; if (s_wre !== 1'b1) begin failures++; $display("FAIL rm_in_strobe got=%b want=1", s_wre); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    req = '0;
    @(negedge clock);
    checks++; if ({s_wre, s_ce} !== 2'b00) begin failures++; $display("FAIL rm_pins got=%b want=00", {s_wre, s_ce}); end
    checks++; if (s_data !== 16'hFFFF) begin failures++; $display("FAIL rm_data_z got=%h want=released(ffff)", s_data); end
    acks = int'(s_ack != 2'b00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (5) begin
      @(negedge clock);
      if (s_ack != 2'b00) acks++;
    end
    @(posedge clock);
    #1;
    checks++; if (acks !== 0) begin failures++; $display("FAIL rm_no_ack got=%0d acks want=0", acks); end
    access(1, 1'b0, 2'b11, a, 16'h0000, lat);
    exp_rd[0] = v;
    checks++; if (lat !== 3) begin failures++; $display("FAIL rm_after_latency got=%0d want=3", lat); end
    checks++; if (s_rdata !== v) begin failures++; $display("FAIL rm_after_rdata got=%h want=%h", s_rdata, v); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] pool [8];
    int lat, p, bi;
    logic wr;
    logic [1:0] b;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, mv;
    pins_t e, m, eb;
    sel = 1'b0;
    viol = 0;
    pool[0] = '0;
    pool[1] = '1;
    for (int k = 2; k < 8; k++) pool[k] = AW'($urandom);
    for (int n = 0; n < 40; n++) begin
      p  = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      b  = wr ? 2'($urandom) : 2'b11;
      a  = pool[$urandom_range(0, 7)];
      wd = DW'($urandom_range(0, 16'hFFFE));
      mv = ref_rd(a);
      access(p, wr, b, a, wd, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL rnd_latency n=%0d got=%0d want=3", n, lat); end
      bi = -1;
      eb = '0;
      for (int i = 0; i <= 3; i++) begin
        tl_expect(i, 0, p, wr, b, a, wd, mv, e, m);
        if ((((snap[i] ^ e) & m) !== '0) && bi < 0) begin bi = i; eb = e; end
      end
      checks++; if (bi >= 0) begin failures++; $display("FAIL rnd_timeline n=%0d cycle=%0d got=%h want=%h", n, bi, snap[bi], eb); end
      if (wr) ref_wr(a, wd, b);
      else exp_rd[0] = mv;
      checks++; if (s_rdata !== exp_rd[0]) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h want=%h", n, s_rdata, exp_rd[0]); end
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL rnd_strobe_overlap got=%0d want=0", viol); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem0[i] = '0;
      mem3[i] = '0;
    end
    test_reset();
    test_single_write();
    test_byte_lane();
    test_contention();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences and shares the single external 256K×16 asynchronous SRAM between two requesters: port 0 is the program loader and port 1 is the Mips memory interface. The block owns the SRAM pins `addr`, `data`, `wre`, `oute`, `hb_mask`, `lb_mask` and `chip_en`. It arbitrates round-robin, latches one request at a time and runs a fixed setup/strobe/recover access sequence. Completion is signalled with a one-cycle acknowledge.

## Interface
- `WAIT_STATES`, default 0: extra strobe cycles per access (0–15).
- `ADDR_W`, default 18: SRAM word-address width.
- `DATA_W`, default 16: SRAM data width (two byte lanes).
- `clock`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `rq_req`  in  2  per-port request level; bit n belongs to port n.
- `rq_we`  in  2  per-port write (1) / read (0).
- `rq_be`  in  4  per-port byte enables; [2n+1] is the high byte, [2n] the low byte.
- `rq_addr`  in  2×ADDR_W  per-port word address; port n is at [n*ADDR_W +: ADDR_W].
- `rq_wdata`  in  2×DATA_W  per-port write data.
- `rq_ack`  out  2  one-cycle completion pulse per port.
- `rq_rdata`  out  DATA_W  read data, shared by both ports.
- `grant_id`  out  1  port that owns the current access.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `addr`  out  ADDR_W  SRAM address.
- `data`  inout  DATA_W  SRAM data; driven only during a write access, high-Z otherwise.
- `wre`  out  1  SRAM write enable, active-high.
- `oute`  out  1  SRAM output enable, active-high.
- `hb_mask`  out  1  high-byte lane enable, active-high.
- `lb_mask`  out  1  low-byte lane enable, active-high.
- `chip_en`  out  1  SRAM chip enable, active-high.

## Operation
- FSM states: IDLE → SETUP → STROBE → RECOVER → IDLE.
- **IDLE:** if any `rq_req` bit is high, pick a winner and latch its we/be/addr/wdata. Also latch `grant_id`, then go to SETUP.
- **Arbitration:** round-robin on a `last` register. On a tie, the port ≠ `last` wins. A single requester always wins. `last` resets to 1, so port 0 wins the first tie.
- **SETUP (1 cycle):**
  - `chip_en`=1; `addr` and the masks take the latched values.
  - Write: `data` is driven. Read: `oute`=1.
- **STROBE (1+WAIT_STATES cycles, down-counter):**
  - Write: `wre`=1.
  - Read: `oute`=1, and `data` is sampled into `rq_rdata` on the last STROBE edge.
- **RECOVER (1 cycle):**
  - `chip_en`, `wre` and `oute` are 0.
  - Write: `data` is still driven (hold time).
  - `rq_ack[grant_id]`=1.
  - Next state is IDLE.
- Latched fields are frozen from IDLE exit to RECOVER. Requester input changes during that window are ignored.
- `rq_be`=00 still runs the full sequence with both masks 0 and is acknowledged (a no-op access).
- A requester must hold `rq_req` until it sees ack, then drop it in the following cycle. If `rq_req` is still high in IDLE, that is a new request.
- `rq_rdata` holds its value until the next read completes. Writes do not change it.

## Timing
- Values after reset (effective on the edge where `reset` is sampled high):
  - FSM = IDLE; `last`=1; `grant_id`=0; `busy`=0.
  - `rq_ack`=00; `rq_rdata`=0; `addr`=0.
  - `wre`=`oute`=`hb_mask`=`lb_mask`=`chip_en`=0; `data` high-Z.
- `reset` in any state aborts the access on that edge. No ack is issued, and the SRAM pins return to reset values in the next cycle.
- Latency from a request seen in IDLE (cycle c0) to ack is 3+WAIT_STATES cycles (ack in cycle c3 when WAIT_STATES=0).
- Throughput is one access per 4+WAIT_STATES cycles, including the IDLE cycle.
- All SRAM outputs and `rq_ack` are registered or decoded purely from state, with no combinational path from `rq_*` inputs.
- `wre` never overlaps `oute`.
- `data` is never driven while `oute`=1.
- `wre` is asserted only when `chip_en`=1 and the address is stable since SETUP.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum (IDLE, SETUP, STROBE, RECOVER);
  - `ADDR_W`/`DATA_W` defaults;
  - port index constants `PORT_LOADER`=0 and `PORT_CPU`=1.
- One sub-module, `rr_arb2`: a two-input round-robin picker with inputs req[1:0], last and output grant. It is purely combinational; `last` is updated in the parent.
- The `data` tri-state is implemented in `sram_arbiter` itself, using one `data_oe` register.

## Test plan
- **Reset:** after reset, all outputs match the reset list, `data` is Z and `busy`=0.
- **Single write, WAIT_STATES=0:**
  - Stimulus: port 0 writes addr 0x00010, data 0xBEEF, be 11.
  - Cycle c2: `wre`=1, `chip_en`=1, `data`=0xBEEF, `addr`=0x00010.
  - Cycle c3: `rq_ack`=01.
  - Read-back from port 1 gives `rq_rdata`=0xBEEF.
- **Byte-lane write:**
  - Port 1 writes 0x12AB with be=01 to an address holding 0xBEEF: `hb_mask`=0 and `lb_mask`=1 during STROBE.
  - A subsequent read returns 0xBEAB.
- **Contention:** both ports request in the same cycle after reset.
  - Port 0 is served first, then port 1.
  - Acks arrive 4 cycles apart, and `grant_id` shows 0 then 1.
- **Wait states:** with WAIT_STATES=3, a read holds `oute`=1 for 4 cycles and acks on cycle c6. `wre` stays 0 throughout.
- **Reset mid-access:** assert `reset` during STROBE of a write.
  - No ack is issued; `wre`/`chip_en` are 0 in the next cycle and `data` is Z.
  - After reset the next request is served normally.
